pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the 16-bit pipelined core. It watches the ID-stage instruction and the destinations of the EX and MEM stages. From these it generates stall, flush, bubble and hold controls for the PC, the IF/ID register and the ID/EX register, and it produces registered forwarding selects that accompany each instruction into EX. It also sequences multi-cycle MUL operations occupying EX and keeps a saturating stall-cycle counter.

---
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and pipe_hazard_ctrl: ID/EX/MEM
// observation inputs plus stall/flush/bubble/hold/forwarding controls back.
interface pipe_hazard_ctrl_if;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_rd;
    logic        ex_wr_en;
    logic        ex_branch_taken;
    logic [3:0]  mem_rd;
    logic        mem_wr_en;

    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        id_ex_hold;
    logic [1:0]  fwd_rs1_sel;
    logic [1:0]  fwd_rs2_sel;
    logic        hz_state;
    logic [15:0] stall_cnt;

    modport master (
        output id_opcode, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_opcode, ex_rd, ex_wr_en, ex_branch_taken,
        output mem_rd, mem_wr_en,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold,
        input  fwd_rs1_sel, fwd_rs2_sel, hz_state, stall_cnt
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_opcode, ex_rd, ex_wr_en, ex_branch_taken,
        input  mem_rd, mem_wr_en,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold,
        output fwd_rs1_sel, fwd_rs2_sel, hz_state, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 16-bit pipelined core.
// Define FORWARDING_EN to enable EX/MEM forwarding with load-use-only stalls.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// RUN      | ID instruction issues unless a branch flush or data hazard wins
// MUL_WAIT | multi-cycle MUL occupies EX; PC, IF/ID and ID/EX are held
module pipe_hazard_ctrl #(
    parameter logic [3:0]  LD_OP      = 4'h8,
    parameter logic [3:0]  MUL_OP     = 4'h4,
    parameter int unsigned MUL_CYCLES = 3
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] MUL_CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state_q;
    state_t      state_nxt;
    logic [3:0]  mul_cnt_q;
    logic [3:0]  mul_cnt_nxt;
    logic [15:0] stall_cnt_q;

    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic issue;
    logic data_hazard;

    logic rs1_ex_match;
    logic rs2_ex_match;
    logic rs1_mem_match;
    logic rs2_mem_match;

    // r0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic src_match(input logic       used,
                                       input logic [3:0] rs,
                                       input logic       wr_en,
                                       input logic [3:0] rd);
        return used && wr_en && (rs == rd) && (rd != 4'd0);
    endfunction

    assign rs1_ex_match  = src_match(hz.id_rs1_used, hz.id_rs1, hz.ex_wr_en,  hz.ex_rd);
    assign rs2_ex_match  = src_match(hz.id_rs2_used, hz.id_rs2, hz.ex_wr_en,  hz.ex_rd);
    assign rs1_mem_match = src_match(hz.id_rs1_used, hz.id_rs1, hz.mem_wr_en, hz.mem_rd);
    assign rs2_mem_match = src_match(hz.id_rs2_used, hz.id_rs2, hz.mem_wr_en, hz.mem_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            mul_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_nxt;
            mul_cnt_q <= mul_cnt_nxt;
        end
    end

    // Controls are forced low while reset is asserted so holds drop immediately.
    always_comb begin
        state_nxt    = state_q;
        mul_cnt_nxt  = mul_cnt_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        issue        = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (data_hazard) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
                        issue = 1'b1;
                        if ((hz.id_opcode == MUL_OP) && (MUL_CYCLES > 1)) begin
                            state_nxt   = MUL_WAIT;
                            mul_cnt_nxt = MUL_CNT_LOAD;
                        end
                    end
                end
                MUL_WAIT: begin
                    // A taken branch cannot be in EX here: EX holds the MUL.
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_hold  = 1'b1;
                    mul_cnt_nxt = mul_cnt_q - 4'd1;
                    if (mul_cnt_q == 4'd1) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt   = RUN;
                    mul_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

`ifdef FORWARDING_EN
    logic [1:0] fwd_rs1_q;
    logic [1:0] fwd_rs2_q;
    logic [1:0] fwd_rs1_nxt;
    logic [1:0] fwd_rs2_nxt;

    function automatic logic [1:0] fwd_code(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return 2'b01;
        end else if (mem_hit) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // Only a load in EX needs a stall; ALU results in EX/MEM are forwarded.
    assign data_hazard = (hz.ex_opcode == LD_OP) && (rs1_ex_match || rs2_ex_match);

    always_comb begin
        fwd_rs1_nxt = fwd_rs1_q;
        fwd_rs2_nxt = fwd_rs2_q;
        if (issue) begin
            fwd_rs1_nxt = fwd_code(rs1_ex_match, rs1_mem_match);
            fwd_rs2_nxt = fwd_code(rs2_ex_match, rs2_mem_match);
        end else if (id_ex_bubble) begin
            fwd_rs1_nxt = 2'b00;
            fwd_rs2_nxt = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_rs1_q <= 2'b00;
            fwd_rs2_q <= 2'b00;
        end else begin
            fwd_rs1_q <= fwd_rs1_nxt;
            fwd_rs2_q <= fwd_rs2_nxt;
        end
    end

    assign hz.fwd_rs1_sel = fwd_rs1_q;
    assign hz.fwd_rs2_sel = fwd_rs2_q;
`else
    logic unused_fwd_inputs;

    // Without forwarding every in-flight writer must drain to WB before issue.
    assign data_hazard = rs1_ex_match || rs2_ex_match || rs1_mem_match || rs2_mem_match;
    assign unused_fwd_inputs = ^{(hz.ex_opcode == LD_OP), issue};

    assign hz.fwd_rs1_sel = 2'b00;
    assign hz.fwd_rs2_sel = 2'b00;
`endif

    assign hz.pc_stall     = pc_stall;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.id_ex_hold   = id_ex_hold;
    assign hz.hz_state     = (state_q == MUL_WAIT);
    assign hz.stall_cnt    = stall_cnt_q;

endmodule
